// File: rtl/multi_port_queue.sv
// multi_port_queue: multi-write/multi-read circular queue with compacted sparse writes; define MPQ_FREE_ON_POP_EN to let same-cycle pops free space for writes
module multi_port_queue #(
  parameter int DEPTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int WPORTS = 4,
  parameter int RPORTS = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush_i,
  input  logic [WPORTS-1:0]            write_valid_i,
  output logic [WPORTS-1:0]            write_ready_o,
  input  logic [WPORTS*DATA_WIDTH-1:0] write_data_i,
  output logic [RPORTS-1:0]            read_valid_o,
  input  logic [RPORTS-1:0]            read_ready_i,
  output logic [RPORTS*DATA_WIDTH-1:0] read_data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         almost_full_o,
  output logic                         full_o,
  output logic                         empty_o
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count, w_free, w_pop_n, w_push_n, w_seen;
  logic [CW-1:0] w_rank [WPORTS];
  logic w_clr, w_run;
  // n never exceeds DEPTH, so one conditional subtract wraps any DEPTH
  function automatic logic [PW-1:0] wrap(input logic [PW-1:0] p, input logic [CW-1:0] n);
    logic [CW:0] s;
    s = (CW+1)'(p) + (CW+1)'(n);
    return s >= (CW+1)'(DEPTH) ? PW'(s - (CW+1)'(DEPTH)) : PW'(s);
  endfunction
  assign w_clr = !rst_n || flush_i;
  always_comb begin
    w_pop_n = '0;
    w_run = 1'b1;
    for (int i = 0; i < RPORTS; i++) begin
      read_valid_o[i] = CW'(i) < r_count;
      read_data_o[i*DATA_WIDTH +: DATA_WIDTH] = r_mem[wrap(r_head, CW'(i))];
      w_run = w_run && read_valid_o[i] && read_ready_i[i];
      w_pop_n = w_pop_n + CW'(w_run);
    end
  end
  // ready ports always form a rank prefix, so push_n is just their count
  always_comb begin
    w_free = CW'(DEPTH) - r_count;
`ifdef MPQ_FREE_ON_POP_EN
    w_free = w_free + w_pop_n;
`endif
    w_seen = '0;
    w_push_n = '0;
    for (int i = 0; i < WPORTS; i++) begin
      w_rank[i] = w_seen;
      write_ready_o[i] = write_valid_i[i] && !w_clr && w_seen < w_free;
      w_seen = w_seen + CW'(write_valid_i[i]);
      w_push_n = w_push_n + CW'(write_ready_o[i]);
    end
  end
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_head <= '0;
      r_tail <= '0;
      r_count <= '0;
    end else begin
      r_head <= wrap(r_head, w_pop_n);
      r_tail <= wrap(r_tail, w_push_n);
      r_count <= r_count + w_push_n - w_pop_n;
    end
  end
  always_ff @(posedge clk)
    for (int i = 0; i < WPORTS; i++)
      if (write_ready_o[i]) r_mem[wrap(r_tail, w_rank[i])] <= write_data_i[i*DATA_WIDTH +: DATA_WIDTH];
  assign count_o = r_count;
  assign almost_full_o = r_count >= CW'(AFULL_THRESH);
  assign full_o = r_count == CW'(DEPTH);
  assign empty_o = r_count == '0;
endmodule

// File: tb/tb_multi_port_queue.sv
// tb_multi_port_queue: two queue instances (DEPTH 16 and non-power-of-2 DEPTH 6) against a queue-based reference model
module tb_multi_port_queue;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, flush;
  logic [3:0] wv, rr, wr0, rv0, wr1, rv1;
  logic [127:0] wd, rd0, rd1;
  logic [4:0] cnt0;
  logic [2:0] cnt1;
  logic af0, fu0, em0, af1, fu1, em1;
  int total = 0, bad = 0;
  typedef struct packed {
    logic [3:0] wr;
    logic [3:0] rv;
    logic [127:0] rd;
    logic [4:0] cnt;
    logic af, fu, em;
  } exp_t;
  logic [31:0] mq [2][$];
  exp_t sb [2][$];
  multi_port_queue u0 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .write_valid_i(wv), .write_ready_o(wr0), .write_data_i(wd),
    .read_valid_o(rv0), .read_ready_i(rr), .read_data_o(rd0),
    .count_o(cnt0), .almost_full_o(af0), .full_o(fu0), .empty_o(em0)
  );
  multi_port_queue #(.DEPTH(6), .AFULL_THRESH(4)) u1 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .write_valid_i(wv), .write_ready_o(wr1), .write_data_i(wd),
    .read_valid_o(rv1), .read_ready_i(rr), .read_data_o(rd1),
    .count_o(cnt1), .almost_full_o(af1), .full_o(fu1), .empty_o(em1)
  );
  function automatic logic [127:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic chk(input string nm, input int k, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s u%0d act=%0h exp=%0h", nm, k, act, exp);
    end
  endtask
  // expected outputs from the current contents, then advance the contents
  task automatic model(input int k, input bit rs, input bit fl, input logic [3:0] v,
                       input logic [127:0] d, input logic [3:0] r, output exp_t e);
    int dep, thr, cnt, popn, free, rank;
    bit run;
    dep = k ? 6 : 16;
    thr = k ? 4 : 12;
    cnt = mq[k].size();
    popn = 0;
    rank = 0;
    run = 1'b1;
    e = '0;
    e.cnt = 5'(cnt);
    e.af = cnt >= thr;
    e.fu = cnt == dep;
    e.em = cnt == 0;
    for (int i = 0; i < 4; i++) begin
      if (i < cnt) begin
        e.rv[i] = 1'b1;
        e.rd[i*32 +: 32] = mq[k][i];
      end
      run = run && i < cnt && r[i];
      if (run) popn++;
    end
    free = dep - cnt;
`ifdef MPQ_FREE_ON_POP_EN
    free += popn;
`endif
    for (int i = 0; i < 4; i++)
      if (v[i]) begin
        e.wr[i] = rank < free && rs && !fl;
        rank++;
      end
    if (!rs || fl) mq[k].delete();
    else begin
      repeat (popn) void'(mq[k].pop_front());
      for (int i = 0; i < 4; i++) if (e.wr[i]) mq[k].push_back(d[i*32 +: 32]);
    end
  endtask
  task automatic cyc(input bit rs, input bit fl, input logic [3:0] v, input logic [127:0] d, input logic [3:0] r);
    exp_t e;
    @(posedge clk);
    #2;
    rst_n = rs;
    flush = fl;
    wv = v;
    wd = d;
    rr = r;
    for (int k = 0; k < 2; k++) begin
      model(k, rs, fl, v, d, r, e);
      sb[k].push_back(e);
    end
  endtask
  initial begin : mon
    exp_t e;
    logic [127:0] m;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++)
        if (sb[k].size() > 0) begin
          e = sb[k].pop_front();
          m = '0;
          for (int i = 0; i < 4; i++) if (e.rv[i]) m[i*32 +: 32] = '1;
          chk("write_ready", k, 128'(k ? wr1 : wr0), 128'(e.wr));
          chk("read_valid", k, 128'(k ? rv1 : rv0), 128'(e.rv));
          chk("read_data", k, (k ? rd1 : rd0) & m, e.rd);
          chk("count", k, 128'(k ? 5'(cnt1) : cnt0), 128'(e.cnt));
          chk("count_le_depth", k, 128'((k ? 5'(cnt1) : cnt0) <= (k ? 5'd6 : 5'd16)), 128'(1));
          chk("flags", k, 128'(k ? {af1, fu1, em1} : {af0, fu0, em0}), 128'({e.af, e.fu, e.em}));
        end
    end
  end
  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    wv = '0;
    rr = '0;
    wd = '0;
    repeat (2) @(posedge clk);
    cyc(0, 0, 4'hf, rnd(), 4'hf);
    cyc(0, 0, 4'hf, rnd(), 4'h0);
    cyc(1, 0, 4'b1010, {32'h33, 32'h0, 32'h11, 32'h0}, 4'h0);
    cyc(1, 0, 4'h0, rnd(), 4'h0);
    repeat (3) cyc(1, 0, 4'hf, rnd(), 4'h0);
    cyc(1, 0, 4'hf, rnd(), 4'h0);
    cyc(1, 0, 4'hf, rnd(), 4'h0);
    cyc(1, 0, 4'b0111, rnd(), 4'b0011);
    cyc(1, 0, 4'h0, rnd(), 4'h0);
    cyc(1, 1, 4'h0, rnd(), 4'h0);
    cyc(1, 0, 4'hf, rnd(), 4'h0);
    cyc(1, 0, 4'h0, rnd(), 4'b1101);
    cyc(1, 0, 4'h0, rnd(), 4'h0);
    cyc(1, 1, 4'h0, rnd(), 4'h0);
    cyc(1, 0, 4'hf, rnd(), 4'h0);
    cyc(1, 0, 4'h0, rnd(), 4'hf);
    cyc(1, 0, 4'hf, rnd(), 4'h0);
    cyc(1, 0, 4'h0, rnd(), 4'hf);
    cyc(1, 0, 4'h0, rnd(), 4'hf);
    cyc(1, 1, 4'h0, rnd(), 4'h0);
    cyc(1, 0, 4'hf, rnd(), 4'h0);
    cyc(1, 0, 4'b0001, rnd(), 4'h0);
    cyc(1, 1, 4'b0011, rnd(), 4'b0001);
    cyc(1, 0, 4'h0, rnd(), 4'h0);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(63) != 0, $urandom_range(31) == 0, 4'($urandom), rnd(),
          (i / 200) % 2 ? 4'($urandom) : 4'($urandom & $urandom & $urandom));
    @(posedge clk);
    #2;
    wv = '0;
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 0, 128'(sb[0].size()), 128'(0));
    chk("scoreboard_drained", 1, 128'(sb[1].size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
